// File: rtl/fetch_sequencer.sv
// SAP-2 instruction-fetch sequencer: fetches opcode plus 0-2 operand bytes, then hands off to execute.
// Optional build macro SINGLE_STEP_EN adds the STEP input and a PAUSE state after each instruction.
module fetch_sequencer #(
  parameter logic [7:0]  HLT_OPCODE  = 8'h76,
  parameter int unsigned WDOG_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic [7:0]  WBUS,
  input  logic [7:0]  opcode,
  input  logic        exec_done,
`ifdef SINGLE_STEP_EN
  input  logic        STEP,
`endif
  output logic        Ep,
  output logic        nLm,
  output logic        Cp,
  output logic        nCE,
  output logic        nLi,
  output logic [15:0] operand,
  output logic [1:0]  op_len,
  output logic        exec_req,
  output logic        halted,
  output logic        fault
);

  localparam int WDOG_W = (WDOG_CYCLES > 32'd1) ? $clog2(WDOG_CYCLES + 32'd1) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST =
    WDOG_W'((WDOG_CYCLES > 32'd0) ? (WDOG_CYCLES - 32'd1) : 32'd0);

  typedef enum logic [3:0] {
    S_IDLE, S_F_ADDR, S_F_READ, S_DECODE, S_O_ADDR, S_O_READ, S_EXEC, S_HALT
`ifdef SINGLE_STEP_EN
    , S_PAUSE
`endif
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic              wdog_exp_s;
  logic              idx_r;
  logic [WDOG_W-1:0] wdog_cnt_r;

  function automatic logic [1:0] len_f(input logic [7:0] op);
    case (op)
      8'h3E, 8'h06, 8'h0E, 8'hE6, 8'hF6, 8'hEE, 8'hDB, 8'hD3: len_f = 2'd2;
      8'hCD, 8'hFA, 8'hC3, 8'hC2, 8'hCA, 8'h3A, 8'h32:        len_f = 2'd3;
      default:                                                len_f = 2'd1;
    endcase
  endfunction

  // Next-state decode, including watchdog expiry out of EXEC
  always_comb begin
    state_nxt_s = state_r;
    wdog_exp_s  = 1'b0;
    case (state_r)
`ifdef SINGLE_STEP_EN
      S_IDLE:   state_nxt_s = STEP ? S_F_ADDR : S_IDLE;
      S_PAUSE:  state_nxt_s = STEP ? S_F_ADDR : S_PAUSE;
`else
      S_IDLE:   state_nxt_s = S_F_ADDR;
`endif
      S_F_ADDR: state_nxt_s = S_F_READ;
      S_F_READ: state_nxt_s = S_DECODE;
      S_DECODE: begin
        if (opcode == HLT_OPCODE) begin
          state_nxt_s = S_HALT;
        end else if (len_f(opcode) == 2'd1) begin
          state_nxt_s = S_EXEC;
        end else begin
          state_nxt_s = S_O_ADDR;
        end
      end
      S_O_ADDR: state_nxt_s = S_O_READ;
      S_O_READ: begin
        if ((2'(idx_r) + 2'd1) < (op_len - 2'd1)) begin
          state_nxt_s = S_O_ADDR;
        end else begin
          state_nxt_s = S_EXEC;
        end
      end
      S_EXEC: begin
        // exec_done on the expiry cycle takes priority over the watchdog
        if (exec_done) begin
`ifdef SINGLE_STEP_EN
          state_nxt_s = S_PAUSE;
`else
          state_nxt_s = S_F_ADDR;
`endif
        end else if ((WDOG_CYCLES != 32'd0) && (wdog_cnt_r == WDOG_LAST)) begin
          state_nxt_s = S_HALT;
          wdog_exp_s  = 1'b1;
        end else begin
          state_nxt_s = S_EXEC;
        end
      end
      S_HALT:   state_nxt_s = S_HALT;
      default:  state_nxt_s = S_IDLE;
    endcase
  end

  // State, datapath and strobes registered from the state being entered
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_r    <= S_IDLE;
      Ep         <= 1'b0;
      nLm        <= 1'b1;
      Cp         <= 1'b0;
      nCE        <= 1'b1;
      nLi        <= 1'b1;
      exec_req   <= 1'b0;
      halted     <= 1'b0;
      fault      <= 1'b0;
      operand    <= 16'h0000;
      op_len     <= 2'd1;
      idx_r      <= 1'b0;
      wdog_cnt_r <= '0;
    end else begin
      state_r  <= state_nxt_s;
      Ep       <= (state_nxt_s == S_F_ADDR) || (state_nxt_s == S_O_ADDR);
      nLm      <= !((state_nxt_s == S_F_ADDR) || (state_nxt_s == S_O_ADDR));
      Cp       <= (state_nxt_s == S_F_READ) || (state_nxt_s == S_O_READ);
      nCE      <= !((state_nxt_s == S_F_READ) || (state_nxt_s == S_O_READ));
      nLi      <= (state_nxt_s != S_F_READ);
      exec_req <= (state_nxt_s == S_EXEC);
      halted   <= (state_nxt_s == S_HALT);
      fault    <= fault | wdog_exp_s;

      case (state_r)
        S_DECODE: begin
          operand <= 16'h0000;
          op_len  <= len_f(opcode);
          idx_r   <= 1'b0;
        end
        S_O_READ: begin
          if (idx_r == 1'b0) begin
            operand[7:0]  <= WBUS;
          end else begin
            operand[15:8] <= WBUS;
          end
          idx_r <= idx_r + 1'b1;
        end
        default: begin
          operand <= operand;
        end
      endcase

      // Counter is held at zero outside EXEC so every EXEC entry starts fresh
      if ((state_r == S_EXEC) && !exec_done) begin
        wdog_cnt_r <= wdog_cnt_r + WDOG_W'(1);
      end else begin
        wdog_cnt_r <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: random program in a memory model, expected
// instruction handoffs queued up front and checked by an independent monitor.
module tb_fetch_sequencer;

  typedef struct {
    int          len;
    logic [15:0] opd;
    int          dur;
  } exp_t;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        exec_done = 1'b0;
  logic        step = 1'b1;
  logic [7:0]  wbus;
  logic [7:0]  ir;
  logic [7:0]  pc;
  logic [7:0]  mar;
  logic [7:0]  mem [256];
  logic        Ep, nLm, Cp, nCE, nLi, exec_req, halted, fault;
  logic [15:0] operand;
  logic [1:0]  op_len;

  exp_t expq[$];
  int   dq[$];
  int   checks = 0;
  int   errors = 0;

  fetch_sequencer #(.HLT_OPCODE(8'h76), .WDOG_CYCLES(4)) dut (
    .CLK(clk), .CLR(clr), .WBUS(wbus), .opcode(ir), .exec_done(exec_done),
`ifdef SINGLE_STEP_EN
    .STEP(step),
`endif
    .Ep(Ep), .nLm(nLm), .Cp(Cp), .nCE(nCE), .nLi(nLi), .operand(operand),
    .op_len(op_len), .exec_req(exec_req), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  // PC / MAR / RAM / IR model around the sequencer
  assign wbus = Ep ? pc : (!nCE ? mem[mar] : 8'h00);
  always @(posedge clk) begin
    if (clr) begin
      pc  <= 8'h00;
      mar <= 8'h00;
      ir  <= 8'h00;
    end else begin
      if (!nLm) mar <= wbus;
      if (Cp) pc <= pc + 8'h01;
      if (!nLi) ir <= wbus;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic int ref_len(input logic [7:0] op);
    logic [7:0] two [8]   = '{8'h3E, 8'h06, 8'h0E, 8'hE6, 8'hF6, 8'hEE, 8'hDB, 8'hD3};
    logic [7:0] three [7] = '{8'hCD, 8'hFA, 8'hC3, 8'hC2, 8'hCA, 8'h3A, 8'h32};
    int n = 1;
    foreach (two[i]) if (two[i] == op) n = 2;
    foreach (three[i]) if (three[i] == op) n = 3;
    return n;
  endfunction

  task automatic clear_mem();
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    expq.delete();
    dq.delete();
  endtask

  // Random program of n instructions ending in HLT; each instruction queues its expected handoff
  task automatic load_random(input int n);
    logic [7:0] two [8]   = '{8'h3E, 8'h06, 8'h0E, 8'hE6, 8'hF6, 8'hEE, 8'hDB, 8'hD3};
    logic [7:0] three [7] = '{8'hCD, 8'hFA, 8'hC3, 8'hC2, 8'hCA, 8'h3A, 8'h32};
    int   addr = 0;
    exp_t e;
    logic [7:0] op;
    logic [7:0] b2, b3;
    clear_mem();
    for (int k = 0; k < n; k++) begin
      case ($urandom_range(0, 2))
        0: op = two[$urandom_range(0, 7)];
        1: op = three[$urandom_range(0, 6)];
        default: begin
          op = 8'($urandom_range(0, 255));
          while (ref_len(op) != 1 || op == 8'h76) op = 8'($urandom_range(0, 255));
        end
      endcase
      b2 = 8'($urandom_range(0, 255));
      b3 = 8'($urandom_range(0, 255));
      e.len = ref_len(op);
      e.opd = (e.len == 1) ? 16'h0000 : (e.len == 2) ? {8'h00, b2} : {b3, b2};
      e.dur = $urandom_range(1, 3);
      mem[addr] = op;
      if (e.len > 1) mem[addr + 1] = b2;
      if (e.len > 2) mem[addr + 2] = b3;
      addr += e.len;
      expq.push_back(e);
      dq.push_back(e.dur);
    end
    mem[addr] = 8'h76;
  endtask

  task automatic wait_halt(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (halted) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  // Execute-controller stand-in: raises exec_done on the d-th EXEC cycle
  initial begin
    bit busy = 1'b0;
    int d = 1;
    int w = 0;
    forever begin
      @(negedge clk);
      if (exec_req && !clr) begin
        if (!busy) begin
          busy = 1'b1;
          d = (dq.size() > 0) ? dq.pop_front() : 1;
          w = 0;
        end
        exec_done = (w == d - 1);
        w++;
      end else begin
        busy = 1'b0;
        exec_done = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on each exec_req rise and checks length, operand, PC steps, latency
  initial begin
    bit   in_instr = 1'b0;
    bit   in_exec = 1'b0;
    int   cyc = 0, cps = 0, dur = 0;
    exp_t e = '{len: 0, opd: 16'h0, dur: 0};
    forever begin
      @(negedge clk);
      if (clr) begin
        in_instr = 1'b0;
        in_exec  = 1'b0;
      end else begin
        if (in_exec && !exec_req) begin
          chk("exec_req_cycles", 32'(dur), 32'(e.dur));
          in_exec  = 1'b0;
          in_instr = 1'b0;
        end
        if (!in_instr && Ep) begin
          in_instr = 1'b1;
          cyc = 0;
          cps = 0;
        end
        if (in_instr) begin
          cyc++;
          if (Cp) cps++;
        end
        if (exec_req && !in_exec) begin
          in_exec = 1'b1;
          dur = 0;
          if (expq.size() == 0) begin
            chk("unexpected_exec", 32'd1, 32'd0);
          end else begin
            e = expq.pop_front();
            chk("op_len", 32'(op_len), 32'(e.len));
            chk("operand", 32'(operand), 32'(e.opd));
            chk("cp_pulses", 32'(cps), 32'(e.len));
            chk("fetch_latency", 32'(cyc), 32'(2 * e.len + 2));
          end
        end
        if (exec_req) dur++;
      end
    end
  end

  initial begin
    exp_t e;
    bit   found;

    // Random instruction stream
    load_random(20);
    repeat (2) @(negedge clk);
    chk("reset_strobes", 32'({Ep, nLm, Cp, nCE, nLi, exec_req}), 32'b010110);
    chk("reset_op_len", 32'(op_len), 32'd1);
    chk("reset_operand", 32'(operand), 32'd0);
    chk("reset_flags", 32'({halted, fault}), 32'd0);
    clr = 1'b0;
    wait_halt("halt_after_stream");
    chk("stream_drained", 32'(expq.size()), 32'd0);
    chk("stream_no_fault", 32'(fault), 32'd0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("halt_quiet", 32'({Ep, nLm, Cp, nCE, nLi, exec_req, halted}), 32'b0101101);
    end

    // Watchdog expiry: exec_done never arrives
    clr = 1'b1;
    clear_mem();
    e = '{len: 1, opd: 16'h0, dur: 4};
    expq.push_back(e);
    dq.push_back(1000);
    repeat (2) @(negedge clk);
    chk("clr_clears_halt", 32'(halted), 32'd0);
    clr = 1'b0;
    wait_halt("wdog_halt");
    chk("wdog_fault", 32'(fault), 32'd1);

    // Watchdog boundary: exec_done on the last allowed cycle
    clr = 1'b1;
    clear_mem();
    mem[1] = 8'h76;
    expq.push_back(e);
    dq.push_back(4);
    repeat (2) @(negedge clk);
    chk("clr_clears_fault", 32'(fault), 32'd0);
    clr = 1'b0;
    wait_halt("boundary_halt");
    chk("boundary_no_fault", 32'(fault), 32'd0);
    chk("boundary_drained", 32'(expq.size()), 32'd0);

    // CLR during an operand read, then clean restart of JMP 1234 with a 3-cycle execute
    clr = 1'b1;
    clear_mem();
    mem[0] = 8'hC3;
    mem[1] = 8'h34;
    mem[2] = 8'h12;
    mem[3] = 8'h76;
    e = '{len: 3, opd: 16'h1234, dur: 3};
    expq.push_back(e);
    dq.push_back(3);
    repeat (2) @(negedge clk);
    clr = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (Cp && nLi) begin
        found = 1'b1;
        break;
      end
    end
    chk("oread_reached", 32'(found), 32'd1);
    clr = 1'b1;
    @(negedge clk);
    chk("abort_strobes", 32'({Ep, nLm, Cp, nCE, nLi, exec_req}), 32'b010110);
    chk("abort_operand", 32'(operand), 32'd0);
    chk("abort_op_len", 32'(op_len), 32'd1);
    @(negedge clk);
    clr = 1'b0;
    wait_halt("restart_halt");
    chk("restart_drained", 32'(expq.size()), 32'd0);
    chk("restart_no_fault", 32'(fault), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
